// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and the baud-divisor helper function.
// Revision    : 1.0 - initial fractional baud generator release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int unsigned c_frac_w = 4;

    typedef struct packed {
        logic [31:0] int_part;
        logic [31:0] frac_part;
    } baud_div_t;

    // Rounds sys_freq / (baud * sample) to the nearest 1/2^c_frac_w step.
    function automatic baud_div_t baud_div(input longint unsigned sys_freq,
                                           input longint unsigned baud,
                                           input longint unsigned sample);
        longint unsigned denom;
        longint unsigned scaled;
        baud_div_t       res;
        denom         = baud * sample;
        scaled        = ((sys_freq << c_frac_w) + (denom >> 1)) / denom;
        res.int_part  = 32'(scaled >> c_frac_w);
        res.frac_part = 32'(scaled & ((64'd1 << c_frac_w) - 64'd1));
        return res;
    endfunction

    localparam baud_div_t   c_default_div  = baud_div(64'd50_000_000, 64'd9600, 64'd16);
    localparam int unsigned c_default_int  = c_default_div.int_part;
    localparam int unsigned c_default_frac = c_default_div.frac_part;

endpackage

`default_nettype wire

// File: rtl/uart_frac_divider.sv
// ============================================================================
// Module      : uart_frac_divider
// Description : Fractional clock divider; period dithers between N and N+1.
// Revision    : 1.0 - initial fractional baud generator release
// ============================================================================
`default_nettype none

module uart_frac_divider
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned DEFAULT_INT  = c_default_int,
    parameter int unsigned DEFAULT_FRAC = c_default_frac
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic              i_phase_clr,
    input  logic              i_load,
    input  logic [DIV_W-1:0]  i_load_int,
    input  logic [FRAC_W-1:0] i_load_frac,
    output logic              o_s_tick
);

    logic [DIV_W-1:0]  r_div_int;
    logic [FRAC_W-1:0] r_div_frac;
    logic [FRAC_W-1:0] r_frac_acc;
    logic [DIV_W-1:0]  r_cnt;

    logic [FRAC_W:0]   w_frac_sum;
    logic [DIV_W-1:0]  w_int_eff;
    logic [DIV_W:0]    w_plen_m1;

    // Divisors below 2 are clamped so the tick can never stay high.
    always_comb begin
        w_frac_sum = {1'b0, r_frac_acc} + {1'b0, r_div_frac};
        w_int_eff  = (r_div_int < DIV_W'(2)) ? DIV_W'(2) : r_div_int;
        w_plen_m1  = {1'b0, w_int_eff} + {{DIV_W{1'b0}}, w_frac_sum[FRAC_W]}
                   - {{DIV_W{1'b0}}, 1'b1};
    end

    assign o_s_tick = i_en & ~i_phase_clr & ({1'b0, r_cnt} == w_plen_m1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_int  <= DIV_W'(DEFAULT_INT);
            r_div_frac <= FRAC_W'(DEFAULT_FRAC);
            r_frac_acc <= '0;
            r_cnt      <= '0;
        end else begin
            if (i_phase_clr) begin
                r_cnt      <= '0;
                r_frac_acc <= '0;
            end else if (i_en) begin
                if (o_s_tick) begin
                    r_cnt      <= '0;
                    r_frac_acc <= w_frac_sum[FRAC_W-1:0];
                end else begin
                    r_cnt <= r_cnt + DIV_W'(1);
                end
            end
            // A new divisor restarts the dither pattern from a clean phase.
            if (i_load) begin
                r_div_int  <= i_load_int;
                r_div_frac <= i_load_frac;
                r_frac_acc <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module      : uart_baud_gen
// Description : Programmable fractional baud generator with oversample/bit ticks.
// Revision    : 1.0 - initial fractional baud generator release
// ============================================================================
`default_nettype none

module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned SAMPLE       = 16,
    parameter int unsigned DEFAULT_INT  = c_default_int,
    parameter int unsigned DEFAULT_FRAC = c_default_frac
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              phase_clr,
    input  logic [DIV_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              s_tick,
    output logic              b_tick
);

    localparam int unsigned c_sub_w = $clog2(SAMPLE);

    logic [DIV_W-1:0]   r_sh_int;
    logic [FRAC_W-1:0]  r_sh_frac;
    logic               r_pend;
    logic [c_sub_w-1:0] r_sub_cnt;

    logic w_s_tick;
    logic w_xfer;
    logic w_apply;
    logic w_sub_last;

    // Apply only on a period boundary while running, so no period is distorted.
    assign w_xfer     = cfg_valid & ~r_pend;
    assign w_apply    = r_pend & (phase_clr | ~en | w_s_tick);
    assign w_sub_last = (r_sub_cnt == c_sub_w'(SAMPLE - 1));

    uart_frac_divider #(
        .DIV_W        (DIV_W),
        .FRAC_W       (FRAC_W),
        .DEFAULT_INT  (DEFAULT_INT),
        .DEFAULT_FRAC (DEFAULT_FRAC)
    ) u_div (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_en         (en),
        .i_phase_clr  (phase_clr),
        .i_load       (w_apply),
        .i_load_int   (r_sh_int),
        .i_load_frac  (r_sh_frac),
        .o_s_tick     (w_s_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_int  <= '0;
            r_sh_frac <= '0;
            r_pend    <= 1'b0;
            r_sub_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_sh_int  <= cfg_int;
                r_sh_frac <= cfg_frac;
                r_pend    <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end

            if (phase_clr) begin
                r_sub_cnt <= '0;
            end else if (w_s_tick) begin
                r_sub_cnt <= w_sub_last ? '0 : r_sub_cnt + c_sub_w'(1);
            end
        end
    end

    assign cfg_ready = ~r_pend;
    assign s_tick    = w_s_tick;
    assign b_tick    = w_s_tick & w_sub_last;

endmodule

`default_nettype wire
